smart_toilet_seq: RTL and testbench
===================================

# smart_toilet_seq

Run sequencer for the smart_toilet microfluidic assay. It drives the three inlet valves (soln1, soln2, soln3) and the outlet valve through a fixed sequence: prime, load, mix, dwell and drain. Each phase lasts a per-run programmable number of clock cycles. The block sits between the host command interface and the valve drivers of the serpentine/diffmix network, and gives the host a start/busy/done handshake plus abort.

## Interface
- CNT_W, default 16: width of every phase-duration input and of the internal counter.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a run; sampled only in IDLE.
- abort  input  1  request early termination; sampled in PRIME, LOAD, MIX and DWELL.
- t_prime, t_load, t_mix, t_dwell, t_drain  input  CNT_W each  phase durations in cycles; latched on an accepted start.
- valve_soln1, valve_soln2, valve_soln3  output  1 each  inlet valve open (1) or closed (0).
- valve_out  output  1  outlet valve open.
- phase  output  3  current state code: IDLE=0, PRIME=1, LOAD=2, MIX=3, DWELL=4, DRAIN=5, DONE=6.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the DONE state.
- aborted  output  1  sticky; set when an abort is accepted, cleared on the next accepted start.

## Operation
- All outputs are registered. Reset value of every output is 0, state is IDLE, and the counter is 0.
- Accepted start: in IDLE with start=1 and abort=0. On acceptance, latch all five durations and clear aborted. If start and abort are both high in IDLE, start is ignored.
- Valve map:
  - PRIME: valve_soln3 only.
  - LOAD: valve_soln2 only.
  - MIX: valve_soln1 and valve_soln2.
  - DWELL: all valves closed.
  - DRAIN: valve_out only.
  - IDLE and DONE: all valves closed.
- Phase order is PRIME → LOAD → MIX → DWELL → DRAIN → DONE → IDLE.
- A phase with a latched duration of 0 is skipped and consumes zero cycles. The transition goes straight to the next phase with a nonzero duration, or to DONE if none remain.
- Counter behaviour: on entry to a phase with duration t, load t-1 and decrement each cycle. Leave the phase on the cycle the counter reads 0. Duration arithmetic is unsigned CNT_W, so the maximum is 2^CNT_W-1 cycles per phase.
- Abort, accepted in PRIME, LOAD, MIX or DWELL:
  - Next state is DRAIN with the full latched t_drain (or DONE if t_drain=0).
  - aborted is set.
  - Abort in DRAIN, DONE or IDLE is ignored and does not set aborted.
- DONE lasts exactly one cycle (done=1, busy=1), then the block returns to IDLE.
- start while busy is ignored. Duration inputs may change freely after acceptance without effect on the current run.
- Reset asserted mid-run: all valves close immediately (asynchronously), state goes to IDLE, aborted is cleared, and no done pulse is produced.

## Timing
- Start sampled at rising edge k: from the output after edge k, busy=1, phase shows the first nonzero phase, and its valves are open.
- Each phase holds its valve pattern for exactly t cycles. Valve outputs switch directly from one phase pattern to the next, with no idle gap inserted.
- Total busy cycles for a full run = t_prime + t_load + t_mix + t_dwell + t_drain + 1 (the DONE cycle).
- All durations 0: after start at edge k, DONE is shown after edge k, and IDLE after edge k+1.
- Abort sampled at edge j: DRAIN pattern from edge j onward, lasting t_drain cycles, followed by DONE.
- Back-to-back runs: the earliest next accepted start is the edge that ends DONE's successor IDLE cycle. Start is never sampled in DONE.

## Test plan
- Nominal run: t_prime=2, t_load=3, t_mix=4, t_dwell=5, t_drain=2, start pulse.
  - Expect soln3 open 2 cycles, soln2 open 3, soln1+soln2 open 4, all closed 5, out open 2, then done for 1 cycle.
  - busy high for 17 cycles; aborted=0.
- Zero skip: t_load=0, t_dwell=0, others 1 → phase sequence 1, 3, 5, 6, 0, with busy for 4 cycles.
- Abort in MIX: same durations as nominal, abort on the 2nd MIX cycle.
  - Expect DRAIN for 2 cycles, then DONE, with aborted=1.
  - aborted stays 1 until the next start, which clears it.
- Protocol: start held high through a run with durations changed mid-run.
  - Run timing uses only the latched values.
  - A new run starts only after IDLE is reached.
  - start+abort together in IDLE leaves the block in IDLE.
- Reset: assert rst_n=0 asynchronously mid-LOAD (off-edge).
  - All outputs read 0 before the next clk edge.
  - No done pulse follows.
  - After release, a start runs normally.
- Saturation: CNT_W=4, t_mix=15 → MIX lasts exactly 15 cycles, with no wrap-around.

Source files
------------

// File: rtl/smart_toilet_seq_if.sv
// Host-to-sequencer bundle: run control, phase durations and valve/status outputs.
// Latency: none (wires only).
// Backpressure: none; start is only honoured when the sequencer is idle.
interface smart_toilet_seq_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] t_prime;
  logic [CNT_W-1:0] t_load;
  logic [CNT_W-1:0] t_mix;
  logic [CNT_W-1:0] t_dwell;
  logic [CNT_W-1:0] t_drain;
  logic             valve_soln1;
  logic             valve_soln2;
  logic             valve_soln3;
  logic             valve_out;
  logic [2:0]       phase;
  logic             busy;
  logic             done;
  logic             aborted;

  // Host side: issues commands and durations, observes valves and status.
  modport master (
    output start, abort, t_prime, t_load, t_mix, t_dwell, t_drain,
    input  valve_soln1, valve_soln2, valve_soln3, valve_out,
    input  phase, busy, done, aborted
  );

  // Sequencer side.
  modport slave (
    input  start, abort, t_prime, t_load, t_mix, t_dwell, t_drain,
    output valve_soln1, valve_soln2, valve_soln3, valve_out,
    output phase, busy, done, aborted
  );
endinterface

// File: rtl/smart_toilet_seq.sv
// Assay run sequencer: prime/load/mix/dwell/drain valve phases with start/busy/done/abort.
// Latency: first phase visible one cycle after the start edge; each phase holds t cycles.
// Backpressure: start ignored while busy or when abort is high; abort honoured before drain.
module smart_toilet_seq #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  smart_toilet_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_LOAD  = 3'd2,
    S_MIX   = 3'd3,
    S_DWELL = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Duration table, index 0 = prime ... index 4 = drain.
  typedef logic [4:0][CNT_W-1:0] dur_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dur_t             dur_q, dur_in;
  logic             latch_dur;
  logic             ab_set, ab_clr;

  logic             soln1_q, soln2_q, soln3_q, out_q;
  logic             busy_q, done_q, aborted_q;

  assign dur_in = {bus.t_drain, bus.t_dwell, bus.t_mix, bus.t_load, bus.t_prime};

  // First phase at or after table index from_idx with a nonzero duration; DONE if none.
  // A state's code equals the table index of the phase that follows it, so passing the
  // current state finds the successor and passing IDLE finds the first phase of a run.
  function automatic state_t first_after(input logic [2:0] from_idx, input dur_t d);
    state_t r;
    logic   found;
    r     = S_DONE;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!found && (i >= int'(from_idx)) && (d[i] != '0)) begin
        r     = state_t'(3'(i + 1));
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Counter preload on phase entry: t-1, so the phase exits when the counter reads 0.
  function automatic logic [CNT_W-1:0] load_val(input state_t s, input dur_t d);
    logic [CNT_W-1:0] t;
    case (s)
      S_PRIME: t = d[0];
      S_LOAD:  t = d[1];
      S_MIX:   t = d[2];
      S_DWELL: t = d[3];
      S_DRAIN: t = d[4];
      default: t = '0;
    endcase
    return (t == '0) ? '0 : (t - ONE);
  endfunction

  // Valve pattern per state as {soln1, soln2, soln3, out}.
  function automatic logic [3:0] valve_map(input state_t s);
    logic [3:0] v;
    case (s)
      S_PRIME: v = 4'b0010;
      S_LOAD:  v = 4'b0100;
      S_MIX:   v = 4'b1100;
      S_DRAIN: v = 4'b0001;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Next-state, counter and latch/abort decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_dur = 1'b0;
    ab_set    = 1'b0;
    ab_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          latch_dur = 1'b1;
          ab_clr    = 1'b1;
          state_d   = first_after(3'd0, dur_in);
          cnt_d     = load_val(state_d, dur_in);
        end
      end
      S_PRIME, S_LOAD, S_MIX, S_DWELL: begin
        if (bus.abort) begin
          // Abort always drains for the full latched drain time.
          ab_set  = 1'b1;
          state_d = (dur_q[4] != '0) ? S_DRAIN : S_DONE;
          cnt_d   = load_val(state_d, dur_q);
        end else if (cnt_q == '0) begin
          state_d = first_after(state_q, dur_q);
          cnt_d   = load_val(state_d, dur_q);
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, latched durations and registered outputs; reset closes all valves at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dur_q     <= '0;
      soln1_q   <= 1'b0;
      soln2_q   <= 1'b0;
      soln3_q   <= 1'b0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_dur) begin
        dur_q <= dur_in;
      end
      {soln1_q, soln2_q, soln3_q, out_q} <= valve_map(state_d);
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
      if (ab_set) begin
        aborted_q <= 1'b1;
      end else if (ab_clr) begin
        aborted_q <= 1'b0;
      end
    end
  end

  assign bus.phase       = state_q;
  assign bus.valve_soln1 = soln1_q;
  assign bus.valve_soln2 = soln2_q;
  assign bus.valve_soln3 = soln3_q;
  assign bus.valve_out   = out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.aborted     = aborted_q;

endmodule

// File: tb/tb_smart_toilet_seq.sv
// Bench for the assay run sequencer: directed and randomized runs against a phase-trace model.
// Latency: outputs compared 1 time unit after every rising edge.
// Backpressure: start/abort driven directly; the model decides which requests are honoured.
module tb_smart_toilet_seq;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  smart_toilet_seq_if #(.CNT_W(CNT_W)) bus ();
  smart_toilet_seq #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int fails  = 0;
  bit model_aborted = 1'b0;

  // Expected {phase, soln1, soln2, soln3, out, busy, done, aborted} for a phase code.
  function automatic logic [9:0] expect_vec(input int ph, input bit ab);
    logic [3:0] v;
    case (ph)
      1:       v = 4'b0010;
      2:       v = 4'b0100;
      3:       v = 4'b1100;
      5:       v = 4'b0001;
      default: v = 4'b0000;
    endcase
    return {3'(ph), v, (ph != 0), (ph == 6), ab};
  endfunction

  function automatic logic [9:0] observe();
    return {bus.phase, bus.valve_soln1, bus.valve_soln2, bus.valve_soln3, bus.valve_out,
            bus.busy, bus.done, bus.aborted};
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = observe();
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_durs(input int a, input int b, input int c, input int d, input int e);
    bus.t_prime = a[CNT_W-1:0];
    bus.t_load  = b[CNT_W-1:0];
    bus.t_mix   = c[CNT_W-1:0];
    bus.t_dwell = d[CNT_W-1:0];
    bus.t_drain = e[CNT_W-1:0];
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s@%0d", tag, i), expect_vec(0, model_aborted));
    end
  endtask

  // One run: expected phase per cycle is each phase code repeated by its duration, then
  // DONE and IDLE. An abort raised during the cycle before position abort_at, while the
  // run is in prime..dwell, replaces the remainder with drain, DONE, IDLE.
  // hold keeps start high and scrambles the duration inputs throughout the run.
  task automatic run(input int tp, input int tl, input int tm, input int tw, input int td,
                     input int abort_at, input bit hold, input string tag);
    int q[$];
    int seq[$];
    int d[5];
    int ab_from;
    d = '{tp, tl, tm, tw, td};
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < d[i]; k++) q.push_back(i + 1);
    q.push_back(6);
    q.push_back(0);
    ab_from = -1;
    if (abort_at > 0 && abort_at < q.size()) begin
      if (q[abort_at-1] >= 1 && q[abort_at-1] <= 4) begin
        for (int i = 0; i < abort_at; i++) seq.push_back(q[i]);
        for (int k = 0; k < td; k++) seq.push_back(5);
        seq.push_back(6);
        seq.push_back(0);
        q = seq;
        ab_from = abort_at;
      end
    end
    set_durs(tp, tl, tm, tw, td);
    bus.start = 1'b1;
    bus.abort = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) model_aborted = 1'b0;
      if (i == ab_from) model_aborted = 1'b1;
      check($sformatf("%s@%0d", tag, i), expect_vec(q[i], model_aborted));
      bus.start = hold;
      bus.abort = (abort_at > 0 && i == abort_at - 1);
      if (hold)
        set_durs($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
    end
    bus.abort = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_durs(0, 0, 0, 0, 0);
    #12;
    check("reset", expect_vec(0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2, "idle");

    // Nominal: 2+3+4+5+2 phase cycles plus DONE gives 17 busy cycles.
    run(2, 3, 4, 5, 2, -1, 1'b0, "nominal");
    bus.start = 1'b0;
    run(1, 0, 1, 0, 1, -1, 1'b0, "zeroskip");
    bus.start = 1'b0;
    run(0, 0, 0, 0, 0, -1, 1'b0, "allzero");
    bus.start = 1'b0;

    // Abort during the 2nd MIX cycle (MIX occupies positions 5..8).
    run(2, 3, 4, 5, 2, 7, 1'b0, "abortmix");
    bus.start = 1'b0;
    idle_cycles(2, "sticky");
    bus.start = 1'b1;
    bus.abort = 1'b1;
    idle_cycles(2, "startabort");
    bus.start = 1'b0;
    bus.abort = 1'b0;
    run(1, 1, 1, 1, 1, -1, 1'b0, "clear");
    bus.start = 1'b0;
    run(3, 2, 1, 1, 0, 2, 1'b0, "abort_nodrain");
    bus.start = 1'b0;
    run(1, 1, 1, 1, 3, 6, 1'b0, "abort_indrain");
    bus.start = 1'b0;

    // Start held high with scrambled durations: runs chain only through IDLE.
    run(2, 1, 2, 1, 1, -1, 1'b1, "hold0");
    run(1, 2, 1, 1, 2, -1, 1'b1, "hold1");
    bus.start = 1'b0;
    idle_cycles(1, "hold_end");

    run(0, 0, 15, 0, 0, -1, 1'b0, "sat");
    bus.start = 1'b0;

    // Asynchronous reset in the middle of LOAD.
    set_durs(2, 5, 1, 1, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    check("rst_prime", expect_vec(1, 1'b0));
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_load", expect_vec(2, 1'b0));
    #3;
    rst_n = 1'b0;
    #1;
    model_aborted = 1'b0;
    check("rst_async", expect_vec(0, 1'b0));
    idle_cycles(3, "rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3, "post_rst");
    run(1, 2, 1, 1, 1, -1, 1'b0, "after_rst");
    bus.start = 1'b0;

    // Randomized runs, some with aborts at arbitrary positions.
    for (int r = 0; r < 25; r++) begin
      int a;
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : -1;
      run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5),
          $urandom_range(0, 5), $urandom_range(0, 5), a, 1'b0, $sformatf("rnd%0d", r));
      bus.start = 1'b0;
      idle_cycles($urandom_range(0, 2), $sformatf("rnd%0d_gap", r));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
